alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Parametrised successor to the single-cycle datapath ALU.
- Registered single-cycle ops (AND/OR/ADD/SUB/SLT/shifts/MFHI/MFLO) plus an internal multi-cycle unsigned multiply/divide unit that owns the HI/LO registers.
- Sits in the EX stage; the pipeline stalls while `ready` is low.

Parameters:
- WIDTH, 32, datapath width in bits (≥8, power of 2).
- SHW, $clog2(WIDTH), shift-amount width.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- valid_in, input, 1, operation request; accepted only when ready=1.
- itype, input, 1, I-type: forces ADD regardless of Signal.
- dataA, input, WIDTH, operand A (rs).
- dataB, input, WIDTH, operand B (rt/imm).
- Signal, input, 6, function code.
- shamt, input, SHW, shift amount.
- ready, output, 1, 1 when idle and able to accept.
- dataOut, output, WIDTH, registered result.
- zero, output, 1, registered (dataA==dataB) of the last accepted op.
- out_valid, output, 1, one-cycle pulse: dataOut updated.
- md_done, output, 1, one-cycle pulse: HI/LO updated.
- div_zero, output, 1, sticky until next accepted DIVU; last DIVU had dataB=0.
- hi, output, WIDTH, HI register.
- lo, output, WIDTH, LO register.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low: rst_n sampled on the clk rising edge.
- Reset values:
  - dataOut=0, zero=0, out_valid=0, md_done=0, div_zero=0, hi=0, lo=0.
  - State=IDLE, ready=1.
  - Reset during MUL/DIV aborts the operation; HI/LO are forced to 0 and no md_done is issued.
- Function codes:
  - SLL=0, SRL=2, SRA=3, MFHI=16, MFLO=18, MULTU=25, DIVU=27.
  - ADD=32, SUB=34, AND=36, OR=37, SLT=42.
- Acceptance: accept = valid_in & ready. Without accept, dataOut/zero hold and out_valid=0.
- Single-cycle ops (latency 1):
  - On the accept edge: dataOut <= result, zero <= (dataA==dataB), out_valid=1 for exactly the next cycle.
  - ADD/SUB: modulo 2^WIDTH, no overflow trap.
  - SLT: true signed compare. Result = (A−B)[MSB] XOR signed-overflow; correct across overflow (e.g. A=0x80000000, B=1 → 1).
  - SLL/SRL/SRA operate on dataB by shamt. SRA replicates dataB[WIDTH−1].
  - MFHI/MFLO return the current hi/lo.
  - itype=1: ADD of dataA+dataB; Signal ignored.
  - Unknown code: dataOut <= 0, out_valid still pulses.
- State machine: IDLE, MUL, DIV. ready = (state==IDLE).
- IDLE → MUL on accept of MULTU:
  - Latch operands; cnt=0.
  - One shift-add step per cycle for WIDTH cycles (cnt 0..WIDTH−1).
  - On the cycle cnt==WIDTH−1 completes: {hi,lo} <= A*B (2·WIDTH-bit unsigned), md_done=1 the next cycle, → IDLE.
  - ready is low for exactly WIDTH cycles after the accept edge.
- IDLE → DIV on accept of DIVU with dataB≠0:
  - Restoring division, one quotient bit per cycle, WIDTH cycles.
  - Then lo <= A/B, hi <= A%B (unsigned), md_done pulse, div_zero <= 0, → IDLE.
- DIVU with dataB==0: completes in 1 cycle, no DIV state. lo <= all-ones, hi <= dataA, div_zero <= 1, md_done pulse.
- MULTU/DIVU do not update dataOut and do not pulse out_valid. zero is still updated at accept.
- valid_in while ready=0 is ignored. No queuing; requester must hold it.
- hi/lo are unchanged throughout MUL/DIV until the completion edge.
- MFHI issued the cycle ready returns high sees the new values.

Test Plan:
- ADD 0xFFFFFFFF+1; SUB 5−7; itype=1, Signal=36, A=3, B=4 → dataOut 0, 0xFFFFFFFE, 7 respectively. Each has out_valid high for exactly one cycle, 1 cycle after accept.
- SLT A=0x80000000, B=1 → 1; A=0x7FFFFFFF, B=0xFFFFFFFF → 0. SRA B=0xF0000000, shamt=4 → 0xFF000000. Signal=63 → 0.
- MULTU A=0xFFFFFFFF, B=2:
  - ready low 32 cycles.
  - Then hi=1, lo=0xFFFFFFFE, md_done pulse.
  - A valid_in ADD during busy is ignored; dataOut unchanged.
- DIVU 100/7 → lo=14, hi=2 after 32 cycles, div_zero=0. Then MFLO → dataOut=14, MFHI → 2.
- DIVU 9/0 → 1 cycle later lo=0xFFFFFFFF, hi=9, div_zero=1. A following DIVU 8/2 clears div_zero: lo=4, hi=0.
- rst_n=0 for 1 cycle at cnt=10 of a MULTU → next cycle ready=1, hi=lo=0, no md_done, dataOut=0. Repeat with WIDTH=16: MULTU 0xFFFF×0xFFFF → hi=0xFFFE, lo=0x0001 after 16 cycles.

Source files
------------

// File: rtl/alu_muldiv.sv
// EX-stage ALU: registered single-cycle ops plus an iterative unsigned multiply/divide
// unit that owns HI/LO. The pipeline stalls while ready is low.
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             itype,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    input  logic [SHW-1:0]   shamt,
    output logic             ready,
    output logic [WIDTH-1:0] dataOut,
    output logic             zero,
    output logic             out_valid,
    output logic             md_done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [5:0] OP_SLL   = 6'd0;
    localparam logic [5:0] OP_SRL   = 6'd2;
    localparam logic [5:0] OP_SRA   = 6'd3;
    localparam logic [5:0] OP_MFHI  = 6'd16;
    localparam logic [5:0] OP_MFLO  = 6'd18;
    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_DIVU  = 6'd27;
    localparam logic [5:0] OP_ADD   = 6'd32;
    localparam logic [5:0] OP_SUB   = 6'd34;
    localparam logic [5:0] OP_AND   = 6'd36;
    localparam logic [5:0] OP_OR    = 6'd37;
    localparam logic [5:0] OP_SLT   = 6'd42;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t               state_reg, state_next;
    logic [SHW-1:0]       cnt_reg;
    logic [2*WIDTH-1:0]   mcand_reg, acc_reg, acc_step;
    logic [WIDTH-1:0]     mplier_reg;
    logic [WIDTH-1:0]     rem_reg, quot_reg, divisor_reg, rem_step, quot_step;
    logic [WIDTH:0]       partial, trial;
    logic [5:0]           op;
    logic                 accept, is_mul, is_div, last_step;
    logic [WIDTH-1:0]     sum, diff, alu_res;
    logic                 slt_bit;

    assign ready     = (state_reg == IDLE);
    assign accept    = valid_in & ready;
    assign op        = itype ? OP_ADD : Signal;
    assign is_mul    = (op == OP_MULTU);
    assign is_div    = (op == OP_DIVU);
    assign last_step = (cnt_reg == SHW'(WIDTH - 1));

    assign sum  = dataA + dataB;
    assign diff = dataA - dataB;
    // Sign of the difference corrected by signed overflow gives a true signed less-than.
    assign slt_bit = diff[WIDTH-1] ^ ((dataA[WIDTH-1] ^ dataB[WIDTH-1]) & (diff[WIDTH-1] ^ dataA[WIDTH-1]));

    always_comb begin
        alu_res = '0;
        unique case (op)
            OP_SLL:  alu_res = dataB << shamt;
            OP_SRL:  alu_res = dataB >> shamt;
            OP_SRA:  alu_res = $signed(dataB) >>> shamt;
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            OP_ADD:  alu_res = sum;
            OP_SUB:  alu_res = diff;
            OP_AND:  alu_res = dataA & dataB;
            OP_OR:   alu_res = dataA | dataB;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            default: alu_res = '0;
        endcase
    end

    assign acc_step = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

    // Restoring division: shift in the next dividend bit, keep the subtraction if it did not borrow.
    assign partial   = {rem_reg, quot_reg[WIDTH-1]};
    assign trial     = partial - {1'b0, divisor_reg};
    assign rem_step  = trial[WIDTH] ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quot_step = {quot_reg[WIDTH-2:0], ~trial[WIDTH]};

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (accept && is_mul)                      state_next = MUL;
                else if (accept && is_div && dataB != '0)  state_next = DIV;
            end
            MUL, DIV: if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dataOut     <= '0;
            zero        <= 1'b0;
            out_valid   <= 1'b0;
            md_done     <= 1'b0;
            div_zero    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            cnt_reg     <= '0;
            mcand_reg   <= '0;
            acc_reg     <= '0;
            mplier_reg  <= '0;
            rem_reg     <= '0;
            quot_reg    <= '0;
            divisor_reg <= '0;
        end else begin
            out_valid <= 1'b0;
            md_done   <= 1'b0;
            if (accept) begin
                zero <= (dataA == dataB);
                if (is_mul) begin
                    mcand_reg  <= {{WIDTH{1'b0}}, dataA};
                    mplier_reg <= dataB;
                    acc_reg    <= '0;
                    cnt_reg    <= '0;
                end else if (is_div) begin
                    if (dataB == '0) begin
                        lo       <= '1;
                        hi       <= dataA;
                        div_zero <= 1'b1;
                        md_done  <= 1'b1;
                    end else begin
                        rem_reg     <= '0;
                        quot_reg    <= dataA;
                        divisor_reg <= dataB;
                        cnt_reg     <= '0;
                    end
                end else begin
                    dataOut   <= alu_res;
                    out_valid <= 1'b1;
                end
            end
            unique case (state_reg)
                MUL: begin
                    acc_reg    <= acc_step;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (last_step) begin
                        {hi, lo} <= acc_step;
                        md_done  <= 1'b1;
                    end
                end
                DIV: begin
                    rem_reg  <= rem_step;
                    quot_reg <= quot_step;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (last_step) begin
                        lo       <= quot_step;
                        hi       <= rem_step;
                        div_zero <= 1'b0;
                        md_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed-vector bench for alu_muldiv: single-cycle ops, MULTU/DIVU timing and results,
// divide-by-zero, mid-operation reset, and a WIDTH=16 instance.
module tb_alu_muldiv;
    localparam logic [5:0] SLL = 6'd0, SRL = 6'd2, SRA = 6'd3, MFHI = 6'd16, MFLO = 6'd18;
    localparam logic [5:0] MULTU = 6'd25, DIVU = 6'd27, ADD = 6'd32, SUB = 6'd34;
    localparam logic [5:0] AND_ = 6'd36, OR_ = 6'd37, SLT = 6'd42;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0, itype = 1'b0;
    logic [31:0] dataA = '0, dataB = '0;
    logic [5:0]  Signal = '0;
    logic [4:0]  shamt = '0;
    logic        ready, zero, out_valid, md_done, div_zero;
    logic [31:0] dataOut, hi, lo;

    logic        s_valid_in = 1'b0, s_itype = 1'b0;
    logic [15:0] s_dataA = '0, s_dataB = '0;
    logic [5:0]  s_Signal = '0;
    logic [3:0]  s_shamt = '0;
    logic        s_ready, s_zero, s_out_valid, s_md_done, s_div_zero;
    logic [15:0] s_dataOut, s_hi, s_lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .itype(itype),
        .dataA(dataA), .dataB(dataB), .Signal(Signal), .shamt(shamt),
        .ready(ready), .dataOut(dataOut), .zero(zero), .out_valid(out_valid),
        .md_done(md_done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    alu_muldiv #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .valid_in(s_valid_in), .itype(s_itype),
        .dataA(s_dataA), .dataB(s_dataB), .Signal(s_Signal), .shamt(s_shamt),
        .ready(s_ready), .dataOut(s_dataOut), .zero(s_zero), .out_valid(s_out_valid),
        .md_done(s_md_done), .div_zero(s_div_zero), .hi(s_hi), .lo(s_lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic single(input string tag, input logic it, input logic [5:0] sig,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                          input logic [31:0] exp);
        @(negedge clk);
        valid_in = 1'b1; itype = it; Signal = sig; dataA = a; dataB = b; shamt = sh;
        @(posedge clk);
        #1 valid_in = 1'b0;
        $display("op %s A=%h B=%h shamt=%0d -> dataOut=%h", tag, a, b, sh, dataOut);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check(tag, 64'(dataOut), 64'(exp));
        @(posedge clk);
        #1 check({tag, "_pulse"}, 64'(out_valid), 64'd0);
    endtask

    // Issues MULTU/DIVU, pokes an ADD while busy, and counts cycles with ready low.
    task automatic md_op(input string tag, input logic [5:0] sig, input logic [31:0] a,
                         input logic [31:0] b, output int cycles, output logic saw_ov);
        @(negedge clk);
        valid_in = 1'b1; itype = 1'b0; Signal = sig; dataA = a; dataB = b;
        @(posedge clk);
        #1 valid_in = 1'b0;
        cycles = 0;
        saw_ov = 1'b0;
        while (!ready && cycles < 100) begin
            if (cycles == 3) begin
                valid_in = 1'b1; Signal = ADD; dataA = 32'd1; dataB = 32'd1;
            end
            if (cycles == 5) valid_in = 1'b0;
            @(posedge clk);
            #1 cycles++;
            if (out_valid) saw_ov = 1'b1;
        end
        valid_in = 1'b0;
        $display("op %s A=%h B=%h busy=%0d hi=%h lo=%h div_zero=%b", tag, a, b, cycles, hi, lo, div_zero);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic ov;
        logic seen;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_dataOut", 64'(dataOut), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_flags", 64'({zero, out_valid, md_done, div_zero}), 64'd0);
        rst_n = 1'b1;

        single("add_wrap", 1'b0, ADD, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0);
        check("add_wrap_zero", 64'(zero), 64'd0);
        single("sub", 1'b0, SUB, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE);
        single("itype", 1'b1, AND_, 32'd3, 32'd4, 5'd0, 32'd7);
        single("slt_ovf", 1'b0, SLT, 32'h8000_0000, 32'd1, 5'd0, 32'd1);
        single("slt_pos", 1'b0, SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'd0);
        single("slt_neg", 1'b0, SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);
        single("sra", 1'b0, SRA, 32'd0, 32'hF000_0000, 5'd4, 32'hFF00_0000);
        single("srl", 1'b0, SRL, 32'd0, 32'hF000_0000, 5'd4, 32'h0F00_0000);
        single("sll", 1'b0, SLL, 32'd0, 32'd3, 5'd31, 32'h8000_0000);
        single("and", 1'b0, AND_, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_F000);
        single("or", 1'b0, OR_, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_FFF0);
        single("unknown", 1'b0, 6'd63, 32'd9, 32'd9, 5'd0, 32'd0);
        single("add_eq", 1'b0, ADD, 32'd7, 32'd7, 5'd0, 32'd14);
        check("add_eq_zero", 64'(zero), 64'd1);
        @(posedge clk);
        #1 check("hold_dataOut", 64'(dataOut), 64'd14);

        md_op("multu", MULTU, 32'hFFFF_FFFF, 32'd2, cyc, ov);
        check("multu_busy", 64'(cyc), 64'd32);
        check("multu_done", 64'(md_done), 64'd1);
        check("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        check("multu_no_ov", 64'(ov), 64'd0);
        check("multu_dataOut", 64'(dataOut), 64'd14);
        check("multu_zero", 64'(zero), 64'd0);
        single("mfhi_ret", 1'b0, MFHI, 32'd0, 32'd0, 5'd0, 32'd1);
        check("multu_done_pulse", 64'(md_done), 64'd0);
        single("mflo_mul", 1'b0, MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFE);

        md_op("divu", DIVU, 32'd100, 32'd7, cyc, ov);
        check("divu_busy", 64'(cyc), 64'd32);
        check("divu_done", 64'(md_done), 64'd1);
        check("divu_hilo", {hi, lo}, {32'd2, 32'd14});
        check("divu_dz", 64'(div_zero), 64'd0);
        single("mflo_div", 1'b0, MFLO, 32'd0, 32'd0, 5'd0, 32'd14);
        single("mfhi_div", 1'b0, MFHI, 32'd0, 32'd0, 5'd0, 32'd2);

        md_op("divu_z", DIVU, 32'd9, 32'd0, cyc, ov);
        check("divz_busy", 64'(cyc), 64'd0);
        check("divz_done", 64'(md_done), 64'd1);
        check("divz_hilo", {hi, lo}, {32'd9, 32'hFFFF_FFFF});
        check("divz_flag", 64'(div_zero), 64'd1);
        @(posedge clk);
        #1 check("divz_sticky", 64'({md_done, div_zero}), 64'b01);

        md_op("divu_8_2", DIVU, 32'd8, 32'd2, cyc, ov);
        check("div82_busy", 64'(cyc), 64'd32);
        check("div82_hilo", {hi, lo}, {32'd0, 32'd4});
        check("div82_dz", 64'(div_zero), 64'd0);

        md_op("divu_z2", DIVU, 32'd9, 32'd0, cyc, ov);
        single("add_pre", 1'b0, ADD, 32'd1, 32'd2, 5'd0, 32'd3);

        @(negedge clk);
        valid_in = 1'b1; itype = 1'b0; Signal = MULTU; dataA = 32'd5; dataB = 32'd3;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        $display("op reset_mid_multu ready=%b hi=%h lo=%h dataOut=%h", ready, hi, lo, dataOut);
        check("rstmid_ready", 64'(ready), 64'd1);
        check("rstmid_hilo", {hi, lo}, 64'd0);
        check("rstmid_dataOut", 64'(dataOut), 64'd0);
        check("rstmid_flags", 64'({md_done, div_zero}), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (md_done) seen = 1'b1;
        end
        check("rstmid_no_done", 64'(seen), 64'd0);

        @(negedge clk);
        s_valid_in = 1'b1; s_Signal = MULTU; s_dataA = 16'hFFFF; s_dataB = 16'hFFFF;
        @(posedge clk);
        #1 s_valid_in = 1'b0;
        cyc = 0;
        while (!s_ready && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        $display("op multu16 A=ffff B=ffff busy=%0d hi=%h lo=%h", cyc, s_hi, s_lo);
        check("m16_busy", 64'(cyc), 64'd16);
        check("m16_done", 64'(s_md_done), 64'd1);
        check("m16_hilo", 64'({s_hi, s_lo}), 64'hFFFE_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
